// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter in front of one shared memory
// port, with a per-transaction wait timeout and a sticky timeout flag.
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   m0_*                    CPU master: read/write strobes, addr, wdata, ack, rdata
//   m1_*                    IO/DMA master: same meaning as m0_*
//   mem_*                   shared memory port (strobes, addr, wdata out; rdata, ack in)
//   timeout_err             sticky, set when any transaction times out
//   stateout                current FSM state (IDLE=0, BUSY0=1, BUSY1=2, DRAIN=3)
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m0_wdata,
  output logic        m0_ack,
  output logic [15:0] m0_rdata,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [15:0] m1_addr,
  input  logic [15:0] m1_wdata,
  output logic        m1_ack,
  output logic [15:0] m1_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        timeout_err,
  output logic [1:0]  stateout
);

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          terr_q, terr_d;

  logic          req0, req1, sel;
  logic          cur_rd, cur_wr;
  logic [DW-1:0] cur_addr, cur_wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;
  assign sel  = (state_q == BUSY1);

  // Mux of the currently owning master's request fields.
  assign cur_rd    = sel ? m1_read  : m0_read;
  assign cur_wr    = sel ? m1_write : m0_write;
  assign cur_addr  = sel ? m1_addr  : m0_addr;
  assign cur_wdata = sel ? m1_wdata : m0_wdata;

  // Next-state and combinational memory/ack decode.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    terr_d    = terr_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ack       = 1'b0;
    rdata     = '0;

    unique case (state_q)
      IDLE: begin
        // m0 wins when alone, or in contention when m1 was served last.
        if (req0 && (!req1 || last_q)) begin
          state_d = BUSY0;
          cnt_d   = '0;
        end else if (req1) begin
          state_d = BUSY1;
          cnt_d   = '0;
        end
      end
      BUSY0, BUSY1: begin
        mem_addr  = cur_addr;
        mem_wdata = cur_wdata;
        // Write takes precedence when both strobes are high.
        mem_write = cur_wr;
        mem_read  = cur_rd & ~cur_wr;
        if (!(cur_rd || cur_wr)) begin
          state_d = IDLE;
        end else if (mem_ack) begin
          ack     = 1'b1;
          rdata   = mem_rdata;
          last_d  = sel;
          state_d = IDLE;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          mem_read  = 1'b0;
          mem_write = 1'b0;
          ack       = 1'b1;
          rdata     = 16'hFFFF;
          terr_d    = 1'b1;
          last_d    = sel;
          state_d   = DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Route the completion to the owning master only.
  assign m0_ack   = ack & ~sel;
  assign m1_ack   = ack & sel;
  assign m0_rdata = sel ? '0 : rdata;
  assign m1_rdata = sel ? rdata : '0;

  assign timeout_err = terr_q;
  assign stateout    = state_q;

  // State registers; last resets to 1 so m0 wins the first contention.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clock, reset;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [15:0] m0_rdata, m1_rdata;
  logic        mem_read, mem_write, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        timeout_err;
  logic [1:0]  stateout;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .m0_read(m0_read), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_read(m1_read), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .timeout_err(timeout_err), .stateout(stateout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [15:0] exp_addr;
    int          who;
    reset = 1'b0;
    m0_read = 0; m0_write = 0; m0_addr = '0; m0_wdata = '0;
    m1_read = 0; m1_write = 0; m1_addr = '0; m1_wdata = '0;
    mem_ack = 0; mem_rdata = '0;

    // Reset state
    step(); #1;
    chk("rst_state", 16'(stateout), 16'd0);
    chk("rst_terr", 16'(timeout_err), 16'd0);
    chk("rst_memrd", 16'(mem_read), 16'd0);
    chk("rst_ack0", 16'(m0_ack), 16'd0);
    do_reset();

    // m0 read of 0x0010, memory acks one cycle later with BEEF
    m0_read = 1; m0_addr = 16'h0010; #1;
    chk("rd_idle_state", 16'(stateout), 16'd0);
    chk("rd_idle_memrd", 16'(mem_read), 16'd0);
    chk("rd_idle_ack", 16'(m0_ack), 16'd0);
    step(); #1;
    chk("rd_busy_state", 16'(stateout), 16'd1);
    chk("rd_busy_memrd", 16'(mem_read), 16'd1);
    chk("rd_busy_addr", mem_addr, 16'h0010);
    chk("rd_busy_ack", 16'(m0_ack), 16'd0);
    chk("rd_busy_rdata0", m0_rdata, 16'h0000);
    step(); mem_ack = 1; mem_rdata = 16'hBEEF; #1;
    chk("rd_ack", 16'(m0_ack), 16'd1);
    chk("rd_rdata", m0_rdata, 16'hBEEF);
    chk("rd_m1ack", 16'(m1_ack), 16'd0);
    chk("rd_m1rdata", m1_rdata, 16'h0000);
    step(); mem_ack = 0; m0_read = 0; #1;
    chk("rd_back_idle", 16'(stateout), 16'd0);

    // Both request from reset: grants alternate m0, m1, m0, m1
    do_reset();
    m0_read = 1; m0_addr = 16'h0A00;
    m1_read = 1; m1_addr = 16'h0B00;
    for (int i = 0; i < 4; i++) begin
      who = i % 2;
      exp_addr = (who == 1) ? 16'h0B00 : 16'h0A00;
      mem_ack = 0; #1;
      chk("rr_idle", 16'(stateout), 16'd0);
      step(); mem_ack = 1; mem_rdata = 16'(16'h1000 + i); #1;
      chk("rr_state", 16'(stateout), 16'(who + 1));
      chk("rr_addr", mem_addr, exp_addr);
      chk("rr_ack0", 16'(m0_ack), 16'(who == 0));
      chk("rr_ack1", 16'(m1_ack), 16'(who == 1));
      step();
    end
    mem_ack = 0; m0_read = 0; m1_read = 0;
    step();

    // m1 write while m0 arrives mid-transaction; last = 1 now
    m1_write = 1; m1_addr = 16'h0200; m1_wdata = 16'h1234; #1;
    step(); m0_read = 1; m0_addr = 16'h0300; #1;
    chk("wr_state", 16'(stateout), 16'd2);
    chk("wr_memwr", 16'(mem_write), 16'd1);
    chk("wr_memrd", 16'(mem_read), 16'd0);
    chk("wr_addr", mem_addr, 16'h0200);
    chk("wr_wdata", mem_wdata, 16'h1234);
    chk("wr_m0ack", 16'(m0_ack), 16'd0);
    step(); #1;
    chk("wr_wait_state", 16'(stateout), 16'd2);
    chk("wr_wait_addr", mem_addr, 16'h0200);
    step(); mem_ack = 1; #1;
    chk("wr_m1ack", 16'(m1_ack), 16'd1);
    chk("wr_m0ack2", 16'(m0_ack), 16'd0);
    step(); mem_ack = 0; m1_write = 0; #1;
    chk("wr_idle", 16'(stateout), 16'd0);
    step(); #1;
    chk("wr_m0_grant", 16'(stateout), 16'd1);
    chk("wr_m0_addr", mem_addr, 16'h0300);
    step(); mem_ack = 1; mem_rdata = 16'h5555; #1;
    chk("wr_m0_rdata", m0_rdata, 16'h5555);
    step(); mem_ack = 0; m0_read = 0;
    step();

    // Timeout with TIMEOUT=4: four wait cycles, then FFFF ack, then DRAIN
    m0_read = 1; m0_addr = 16'h0040;
    for (int i = 0; i < 4; i++) begin
      step(); #1;
      chk("to_wait_memrd", 16'(mem_read), 16'd1);
      chk("to_wait_ack", 16'(m0_ack), 16'd0);
    end
    step(); #1;
    chk("to_state", 16'(stateout), 16'd1);
    chk("to_ack", 16'(m0_ack), 16'd1);
    chk("to_rdata", m0_rdata, 16'hFFFF);
    chk("to_memrd", 16'(mem_read), 16'd0);
    chk("to_terr_pre", 16'(timeout_err), 16'd0);
    step(); m0_read = 0; mem_ack = 1; #1;
    chk("drain_state", 16'(stateout), 16'd3);
    chk("drain_terr", 16'(timeout_err), 16'd1);
    chk("drain_ack0", 16'(m0_ack), 16'd0);
    chk("drain_ack1", 16'(m1_ack), 16'd0);
    chk("drain_memrd", 16'(mem_read), 16'd0);
    step(); mem_ack = 0; #1;
    chk("drain_exit", 16'(stateout), 16'd0);
    chk("terr_sticky", 16'(timeout_err), 16'd1);

    // m1 aborts in BUSY1, pending m0 is granted afterwards
    m1_read = 1; m1_addr = 16'h0500;
    step(); m0_read = 1; m0_addr = 16'h0600; #1;
    chk("ab_state", 16'(stateout), 16'd2);
    step(); m1_read = 0; #1;
    chk("ab_m1ack", 16'(m1_ack), 16'd0);
    chk("ab_memrd", 16'(mem_read), 16'd0);
    step(); #1;
    chk("ab_idle", 16'(stateout), 16'd0);
    chk("ab_idle_m1ack", 16'(m1_ack), 16'd0);
    step(); #1;
    chk("ab_m0_grant", 16'(stateout), 16'd1);
    chk("ab_m0_addr", mem_addr, 16'h0600);
    step(); mem_ack = 1; mem_rdata = 16'h6666; #1;
    chk("ab_m0_ack", 16'(m0_ack), 16'd1);
    step(); mem_ack = 0; m0_read = 0;
    step();

    // Reset pulsed during BUSY0
    m0_read = 1; m0_addr = 16'h0700;
    step(); #1;
    chk("rb_busy", 16'(stateout), 16'd1);
    reset = 1'b0; #1;
    chk("rb_state", 16'(stateout), 16'd0);
    chk("rb_memrd", 16'(mem_read), 16'd0);
    chk("rb_ack", 16'(m0_ack), 16'd0);
    chk("rb_terr", 16'(timeout_err), 16'd0);
    step(); reset = 1'b1; #1;
    chk("rb_idle", 16'(stateout), 16'd0);
    step(); #1;
    chk("rb_regrant", 16'(stateout), 16'd1);
    step(); mem_ack = 1; mem_rdata = 16'h7777; #1;
    chk("rb_ack2", 16'(m0_ack), 16'd1);
    chk("rb_rdata2", m0_rdata, 16'h7777);
    step(); mem_ack = 0; m0_read = 0;
    step();

    // Read and write both high: only mem_write asserted
    m0_read = 1; m0_write = 1; m0_addr = 16'h0800; m0_wdata = 16'hAAAA;
    step(); #1;
    chk("rw_memwr", 16'(mem_write), 16'd1);
    chk("rw_memrd", 16'(mem_read), 16'd0);
    chk("rw_wdata", mem_wdata, 16'hAAAA);
    step(); mem_ack = 1; #1;
    chk("rw_ack", 16'(m0_ack), 16'd1);
    step(); mem_ack = 0; m0_read = 0; m0_write = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
